tspi_req_arbiter: RTL and testbench



---
 rtl/tspi_req_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_tspi_req_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tspi_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tspi_req_arbiter                                                  |
// | Desc    : Round-robin arbiter/sequencer sharing one tSPI host register port |
// |           among NumReq requesters, with locked multi-access sequences.      |
// |           Optional response watchdog: define TSPI_ARB_TIMEOUT_EN.           |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tspi_req_arbiter #(
  parameter int NumReq        = 3,
  parameter int AddrWidth     = 8,
  parameter int TimeoutCycles = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumReq-1:0]           s_req_i,
  input  logic [NumReq-1:0]           s_lock_i,
  input  logic [NumReq*AddrWidth-1:0] s_addr_i,
  input  logic [NumReq-1:0]           s_we_i,
  input  logic [NumReq*32-1:0]        s_wdata_i,
  output logic [NumReq-1:0]           s_gnt_o,
  output logic [NumReq-1:0]           s_rvalid_o,
  output logic [31:0]                 s_rdata_o,
  output logic                        s_err_o,
  output logic                        m_req_o,
  output logic [AddrWidth-1:0]        m_addr_o,
  output logic                        m_we_o,
  output logic [31:0]                 m_wdata_o,
  input  logic                        m_gnt_i,
  input  logic                        m_rvalid_i,
  input  logic [31:0]                 m_rdata_i,
  input  logic                        m_err_i,
  output logic [$clog2(NumReq)-1:0]   owner_o,
  output logic                        busy_o
);

  localparam int OwnerW = $clog2(NumReq);

  if (NumReq < 2 || NumReq > 8 || TimeoutCycles < 1) begin : g_param_check
    $error("tspi_req_arbiter: NumReq must be 2..8 and TimeoutCycles >= 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  state_e                 state_q;
  logic [OwnerW-1:0]      rr_q;
  logic [OwnerW-1:0]      owner_q;
  logic                   m_req_q;
  logic [AddrWidth-1:0]   m_addr_q;
  logic                   m_we_q;
  logic [31:0]            m_wdata_q;

  logic                   win_found;
  logic [OwnerW-1:0]      win_idx;
  logic [OwnerW-1:0]      sel_idx;
  logic [OwnerW-1:0]      owner_nxt;
  logic [NumReq-1:0]      owner_oh;
  logic                   resp_hit;
  logic                   tmo_hit;

  // First requester at or after the round-robin pointer, wrapping modulo NumReq.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int i = 0; i < NumReq; i++) begin
      idx = (int'(rr_q) + i) % NumReq;
      if (!win_found && s_req_i[idx]) begin
        win_found = 1'b1;
        win_idx   = OwnerW'(idx);
      end
    end
  end

  assign sel_idx   = (state_q == ST_HOLD) ? owner_q : win_idx;
  assign owner_nxt = (owner_q == OwnerW'(NumReq - 1)) ? '0 : owner_q + 1'b1;
  assign owner_oh  = NumReq'(1) << owner_q;
  assign resp_hit  = (state_q == ST_WAIT) && m_rvalid_i;

`ifdef TSPI_ARB_TIMEOUT_EN
  logic [31:0] cnt_q;
  assign tmo_hit = (state_q == ST_WAIT) && !m_rvalid_i && (cnt_q == 32'(TimeoutCycles - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      rr_q      <= '0;
      owner_q   <= '0;
      m_req_q   <= 1'b0;
      m_addr_q  <= '0;
      m_we_q    <= 1'b0;
      m_wdata_q <= '0;
`ifdef TSPI_ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            owner_q   <= win_idx;
            m_addr_q  <= s_addr_i[sel_idx*AddrWidth +: AddrWidth];
            m_we_q    <= s_we_i[sel_idx];
            m_wdata_q <= s_wdata_i[sel_idx*32 +: 32];
            m_req_q   <= 1'b1;
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // A response coinciding with the grant is ignored; only the grant counts.
          if (m_gnt_i) begin
            m_req_q <= 1'b0;
            state_q <= ST_WAIT;
`ifdef TSPI_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        ST_WAIT: begin
          if (m_rvalid_i) begin
            if (s_lock_i[owner_q]) begin
              state_q <= ST_HOLD;
            end else begin
              rr_q    <= owner_nxt;
              state_q <= ST_IDLE;
            end
          end
`ifdef TSPI_ARB_TIMEOUT_EN
          else if (tmo_hit) begin
            cnt_q   <= '0;
            state_q <= ST_DRAIN;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
`endif
        end
        ST_HOLD: begin
          if (s_req_i[owner_q]) begin
            m_addr_q  <= s_addr_i[sel_idx*AddrWidth +: AddrWidth];
            m_we_q    <= s_we_i[sel_idx];
            m_wdata_q <= s_wdata_i[sel_idx*32 +: 32];
            m_req_q   <= 1'b1;
            state_q   <= ST_ISSUE;
          end else if (!s_lock_i[owner_q]) begin
            rr_q    <= owner_nxt;
            state_q <= ST_IDLE;
          end
        end
`ifdef TSPI_ARB_TIMEOUT_EN
        ST_DRAIN: begin
          // Swallow the late response, or give up after a second full timeout.
          if (m_rvalid_i || (cnt_q == 32'(TimeoutCycles - 1))) begin
            rr_q    <= owner_nxt;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_gnt_o    = ((state_q == ST_ISSUE) && m_gnt_i) ? owner_oh : '0;
  assign s_rvalid_o = (resp_hit || tmo_hit) ? owner_oh : '0;
  assign s_rdata_o  = resp_hit ? m_rdata_i : (tmo_hit ? 32'hDEAD_BEEF : 32'h0);
  assign s_err_o    = resp_hit ? m_err_i : tmo_hit;
  assign m_req_o    = m_req_q;
  assign m_addr_o   = m_addr_q;
  assign m_we_o     = m_we_q;
  assign m_wdata_o  = m_wdata_q;
  assign owner_o    = owner_q;
  assign busy_o     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tspi_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_tspi_req_arbiter                                               |
// | Desc    : Directed scenarios plus randomized traffic against a transaction- |
// |           level round-robin reference model.                                |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_tspi_req_arbiter;

  localparam int NR  = 3;
  localparam int AW  = 8;
  localparam int TMO = 16;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NR-1:0]     s_req_i, s_lock_i, s_we_i;
  logic [NR*AW-1:0]  s_addr_i;
  logic [NR*32-1:0]  s_wdata_i;
  logic [NR-1:0]     s_gnt_o, s_rvalid_o;
  logic [31:0]       s_rdata_o;
  logic              s_err_o;
  logic              m_req_o, m_we_o;
  logic [AW-1:0]     m_addr_o;
  logic [31:0]       m_wdata_o;
  logic              m_gnt_i, m_rvalid_i, m_err_i;
  logic [31:0]       m_rdata_i;
  logic [1:0]        owner_o;
  logic              busy_o;

  always #5 clk_i = ~clk_i;

  tspi_req_arbiter #(.NumReq(NR), .AddrWidth(AW), .TimeoutCycles(TMO)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_req_i(s_req_i), .s_lock_i(s_lock_i), .s_addr_i(s_addr_i), .s_we_i(s_we_i),
    .s_wdata_i(s_wdata_i), .s_gnt_o(s_gnt_o), .s_rvalid_o(s_rvalid_o),
    .s_rdata_o(s_rdata_o), .s_err_o(s_err_o), .m_req_o(m_req_o), .m_addr_o(m_addr_o),
    .m_we_o(m_we_o), .m_wdata_o(m_wdata_o), .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i),
    .m_rdata_i(m_rdata_i), .m_err_i(m_err_i), .owner_o(owner_o), .busy_o(busy_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_pl(input int i, input logic [AW-1:0] a, input logic w, input logic [31:0] d);
    s_addr_i[i*AW +: AW] = a;
    s_we_i[i]            = w;
    s_wdata_i[i*32 +: 32] = d;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    s_req_i = '0; s_lock_i = '0; s_we_i = '0; s_addr_i = '0; s_wdata_i = '0;
    m_gnt_i = 1'b0; m_rvalid_i = 1'b0; m_rdata_i = '0; m_err_i = 1'b0;
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk_eq({tag, "_gnt"}, s_gnt_o, 0);
    chk_eq({tag, "_rvalid"}, s_rvalid_o, 0);
    chk_eq({tag, "_rdata"}, s_rdata_o, 0);
    chk_eq({tag, "_err"}, s_err_o, 0);
    chk_eq({tag, "_mreq"}, m_req_o, 0);
    chk_eq({tag, "_maddr"}, m_addr_o, 0);
    chk_eq({tag, "_mwe"}, m_we_o, 0);
    chk_eq({tag, "_mwdata"}, m_wdata_o, 0);
    chk_eq({tag, "_owner"}, owner_o, 0);
    chk_eq({tag, "_busy"}, busy_o, 0);
  endtask

  task automatic wait_mreq(input string tag);
    for (int k = 0; k < 20 && !m_req_o; k++) step();
    chk_eq({tag, "_mreq"}, m_req_o, 1);
  endtask

  // Host: grant after gd ISSUE cycles, respond rd cycles after the grant.
  task automatic host_serve(input int gd, input int rd, input logic [31:0] rdat, input logic err,
                            output logic [NR-1:0] g_seen, output logic mreq_wait,
                            output logic [NR-1:0] rv_seen, output logic [31:0] rd_seen,
                            output logic er_seen);
    repeat (gd) step();
    m_gnt_i = 1'b1;
    #1 g_seen = s_gnt_o;
    step();
    m_gnt_i = 1'b0;
    mreq_wait = m_req_o;
    repeat (rd - 1) step();
    m_rvalid_i = 1'b1; m_rdata_i = rdat; m_err_i = err;
    #1;
    rv_seen = s_rvalid_o; rd_seen = s_rdata_o; er_seen = s_err_o;
    step();
    m_rvalid_i = 1'b0; m_rdata_i = '0; m_err_i = 1'b0;
  endtask

  logic [NR-1:0] g_seen, rv_seen;
  logic [31:0]   rd_seen;
  logic          er_seen, mreq_wait;

  // Random-phase state and reference model
  logic [AW-1:0] p_addr [NR];
  logic          p_we   [NR];
  logic [31:0]   p_wdata[NR];
  int            rq_st  [NR];
  bit            rq_keep[NR];
  int            m_rr, exp_owner, h_phase, h_cnt, n_resp, cyc, w;
  bit            prev_mreq, found, gnt_now, rv_now, idle_next;
  logic [NR-1:0] last_req, exp_vec;
  logic [31:0]   r_data;
  logic          r_err;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    do_reset();
    #1 check_zero("reset");

    // Single access: requester 1 writes 0x19 to 0x04
    s_req_i = 3'b010;
    set_pl(1, 8'h04, 1'b1, 32'h0000_0019);
    step();
    s_req_i = '0;
    #1;
    chk_eq("single_mreq_latency", m_req_o, 1);
    chk_eq("single_maddr", m_addr_o, 8'h04);
    chk_eq("single_mwe", m_we_o, 1);
    chk_eq("single_mwdata", m_wdata_o, 32'h19);
    chk_eq("single_owner", owner_o, 1);
    host_serve(1, 3, 32'h0, 1'b0, g_seen, mreq_wait, rv_seen, rd_seen, er_seen);
    chk_eq("single_gnt", g_seen, 3'b010);
    chk_eq("single_mreq_wait", mreq_wait, 0);
    chk_eq("single_rvalid", rv_seen, 3'b010);
    #1 chk_eq("single_busy_after", busy_o, 0);
    // rr now 2: with 0 and 2 requesting, 2 wins
    s_req_i = 3'b101;
    set_pl(0, 8'h10, 1'b1, 32'h1);
    set_pl(2, 8'h20, 1'b1, 32'h2);
    step();
    chk_eq("single_rr2_owner", owner_o, 2);
    chk_eq("single_rr2_addr", m_addr_o, 8'h20);
    s_req_i = 3'b001;
    host_serve(0, 1, 32'h0, 1'b0, g_seen, mreq_wait, rv_seen, rd_seen, er_seen);
    wait_mreq("single_wrap");
    chk_eq("single_wrap_owner", owner_o, 0);
    s_req_i = '0;
    host_serve(0, 1, 32'h0, 1'b0, g_seen, mreq_wait, rv_seen, rd_seen, er_seen);

    // Fairness: all three hold requests from rr = 0
    do_reset();
    s_req_i = 3'b111;
    for (int i = 0; i < NR; i++) set_pl(i, AW'(8'h50 + i), 1'b0, 32'h0);
    for (int t = 0; t < 6; t++) begin
      wait_mreq("fair");
      chk_eq("fair_owner", owner_o, t % 3);
      host_serve(int'($urandom_range(0, 2)), int'($urandom_range(1, 3)), 32'hC0DE_0000 + t, 1'b0,
                 g_seen, mreq_wait, rv_seen, rd_seen, er_seen);
      chk_eq("fair_gnt", g_seen, 3'b001 << (t % 3));
      chk_eq("fair_rvalid", rv_seen, 3'b001 << (t % 3));
      chk_eq("fair_rdata", rd_seen, 32'hC0DE_0000 + t);
    end
    s_req_i = '0;
    step();

    // Lock: requester 2 command + 4 reads while 0 and 1 wait
    s_req_i = 3'b100; s_lock_i = 3'b100;
    set_pl(2, 8'h30, 1'b1, 32'hC0AA_0001);
    wait_mreq("lock_cmd");
    chk_eq("lock_cmd_owner", owner_o, 2);
    chk_eq("lock_cmd_addr", m_addr_o, 8'h30);
    s_req_i = 3'b111;
    set_pl(0, 8'h08, 1'b0, 32'h0);
    set_pl(1, 8'h0C, 1'b0, 32'h0);
    host_serve(0, 2, 32'h0, 1'b0, g_seen, mreq_wait, rv_seen, rd_seen, er_seen);
    chk_eq("lock_cmd_rvalid", rv_seen, 3'b100);
    for (int k = 0; k < 4; k++) begin
      set_pl(2, AW'(8'h40 + k), 1'b0, 32'h0);
      step();
      if (k == 3) s_req_i[2] = 1'b0;
      #1;
      chk_eq("lock_data_mreq", m_req_o, 1);
      chk_eq("lock_data_owner", owner_o, 2);
      chk_eq("lock_data_addr", m_addr_o, 8'h40 + k);
      host_serve(1, 2, 32'hA0 + k, 1'b0, g_seen, mreq_wait, rv_seen, rd_seen, er_seen);
      chk_eq("lock_data_gnt", g_seen, 3'b100);
      chk_eq("lock_data_rdata", rd_seen, 32'hA0 + k);
    end
    #1;
    chk_eq("lock_hold_busy", busy_o, 1);
    chk_eq("lock_hold_mreq", m_req_o, 0);
    step();
    chk_eq("lock_hold2_mreq", m_req_o, 0);
    s_lock_i = '0;
    wait_mreq("lock_release");
    chk_eq("lock_release_owner", owner_o, 0);

    // Error passthrough on requester 0 read
    host_serve(0, 2, 32'h1234_5678, 1'b1, g_seen, mreq_wait, rv_seen, rd_seen, er_seen);
    chk_eq("err_rvalid", rv_seen, 3'b001);
    chk_eq("err_rdata", rd_seen, 32'h1234_5678);
    chk_eq("err_flag", er_seen, 1);
    s_req_i = 3'b010;
    wait_mreq("err_next");
    chk_eq("err_next_owner", owner_o, 1);
    s_req_i = '0;
    host_serve(0, 1, 32'h0, 1'b0, g_seen, mreq_wait, rv_seen, rd_seen, er_seen);

    // Reset mid-WAIT (rr is 2 before the reset)
    s_req_i = 3'b100;
    wait_mreq("rstw");
    s_req_i = '0;
    m_gnt_i = 1'b1;
    step();
    m_gnt_i = 1'b0;
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    m_rvalid_i = 1'b1; m_rdata_i = 32'h5555_AAAA;
    #1 check_zero("rstw");
    step();
    m_rvalid_i = 1'b0; m_rdata_i = '0;
    s_req_i = 3'b101;
    wait_mreq("rstw_rr");
    chk_eq("rstw_rr_owner", owner_o, 0);
    s_req_i = '0;
    host_serve(0, 1, 32'h0, 1'b0, g_seen, mreq_wait, rv_seen, rd_seen, er_seen);

    // Response watchdog behaviour
    do_reset();
    s_req_i = 3'b001;
    wait_mreq("tmo");
    s_req_i = '0;
    m_gnt_i = 1'b1;
    step();
    m_gnt_i = 1'b0;
`ifdef TSPI_ARB_TIMEOUT_EN
    for (int k = 1; k < TMO; k++) begin
      #1 chk_eq("tmo_quiet", s_rvalid_o, 0);
      step();
    end
    #1;
    chk_eq("tmo_rvalid", s_rvalid_o, 3'b001);
    chk_eq("tmo_err", s_err_o, 1);
    chk_eq("tmo_rdata", s_rdata_o, 32'hDEAD_BEEF);
    for (int k = TMO + 1; k < 20; k++) begin
      step();
      #1 chk_eq("tmo_drain_busy", busy_o, 1);
    end
    step();
    m_rvalid_i = 1'b1; m_rdata_i = 32'h1111_2222;
    #1;
    chk_eq("tmo_late_dropped", s_rvalid_o, 0);
    chk_eq("tmo_late_rdata", s_rdata_o, 0);
    step();
    m_rvalid_i = 1'b0; m_rdata_i = '0;
    #1 chk_eq("tmo_idle", busy_o, 0);
`else
    for (int k = 0; k < 40; k++) begin
      #1;
      chk_eq("wait_quiet", s_rvalid_o, 0);
      chk_eq("wait_busy", busy_o, 1);
      step();
    end
    m_rvalid_i = 1'b1; m_rdata_i = 32'h0BAD_F00D;
    #1;
    chk_eq("wait_late_rvalid", s_rvalid_o, 3'b001);
    chk_eq("wait_late_rdata", s_rdata_o, 32'h0BAD_F00D);
    step();
    m_rvalid_i = 1'b0; m_rdata_i = '0;
`endif

    // Randomized traffic against the transaction-level model
    do_reset();
    m_rr = 0; exp_owner = 0; h_phase = 0; h_cnt = 0; n_resp = 0; cyc = 0;
    prev_mreq = 1'b0; idle_next = 1'b0; last_req = '0; r_data = '0; r_err = 1'b0;
    for (int i = 0; i < NR; i++) begin
      rq_st[i] = 0; rq_keep[i] = 1'b0; p_addr[i] = '0; p_we[i] = 1'b0; p_wdata[i] = '0;
    end
    while (n_resp < 150 && cyc < 20000) begin
      step();
      cyc++;
      if (m_req_o && !prev_mreq) begin
        found = 1'b0; w = 0;
        for (int off = 0; off < NR; off++) begin
          if (!found && last_req[(m_rr + off) % NR]) begin
            found = 1'b1;
            w = (m_rr + off) % NR;
          end
        end
        chk_eq("rnd_arb_has_req", found, 1);
        chk_eq("rnd_owner", owner_o, w);
        chk_eq("rnd_maddr", m_addr_o, p_addr[w]);
        chk_eq("rnd_mwe", m_we_o, p_we[w]);
        chk_eq("rnd_mwdata", m_wdata_o, p_wdata[w]);
        exp_owner = w;
        rq_st[w] = 2;
        rq_keep[w] = 1'($urandom_range(0, 1));
        h_phase = 1;
        h_cnt = int'($urandom_range(0, 3));
      end
      prev_mreq = m_req_o;
      if (idle_next) begin
        chk_eq("rnd_turnaround_idle", busy_o, 0);
        idle_next = 1'b0;
      end
      for (int i = 0; i < NR; i++) begin
        if (rq_st[i] == 0 && $urandom_range(0, 3) == 0) begin
          rq_st[i] = 1;
          p_addr[i] = AW'($urandom);
          p_we[i] = 1'($urandom);
          p_wdata[i] = $urandom;
        end
        s_req_i[i] = (rq_st[i] == 1) || (rq_st[i] == 2 && rq_keep[i]);
        set_pl(i, p_addr[i], p_we[i], p_wdata[i]);
      end
      gnt_now = 1'b0; rv_now = 1'b0;
      m_gnt_i = 1'b0; m_rvalid_i = 1'b0; m_rdata_i = '0; m_err_i = 1'b0;
      if (h_phase == 1) begin
        if (h_cnt == 0) begin
          m_gnt_i = 1'b1; gnt_now = 1'b1;
          h_phase = 2;
          h_cnt = int'($urandom_range(0, 3));
          if ($urandom_range(0, 3) == 0) begin
            m_rvalid_i = 1'b1; m_rdata_i = $urandom; m_err_i = 1'b1;
          end
        end else h_cnt--;
      end else if (h_phase == 2) begin
        if (h_cnt == 0) begin
          r_data = $urandom; r_err = 1'($urandom);
          m_rvalid_i = 1'b1; m_rdata_i = r_data; m_err_i = r_err;
          rv_now = 1'b1;
          h_phase = 0;
        end else h_cnt--;
      end
      last_req = s_req_i;
      #1;
      exp_vec = gnt_now ? (NR'(1) << exp_owner) : '0;
      chk_eq("rnd_gnt", s_gnt_o, exp_vec);
      exp_vec = rv_now ? (NR'(1) << exp_owner) : '0;
      chk_eq("rnd_rvalid", s_rvalid_o, exp_vec);
      chk_eq("rnd_rdata", s_rdata_o, rv_now ? r_data : 32'h0);
      chk_eq("rnd_err", s_err_o, rv_now ? r_err : 1'b0);
      if (gnt_now) rq_st[exp_owner] = 0;
      if (rv_now) begin
        m_rr = (exp_owner + 1) % NR;
        n_resp++;
        idle_next = 1'b1;
      end
    end
    chk_eq("rnd_completed_budget", n_resp >= 150, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
